// File: rtl/pipe_rxdetect_ctrl.sv
// PIPE receiver-detection sequencer: parks enabled lanes in P1 with idle transmitters,
// pulses TxDetectRx_Loopback and collects per-lane PhyStatus/RxStatus into a detected-lane mask.
module pipe_rxdetect_ctrl #(
    parameter int LANESNUMBER    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LANESNUMBER-1:0]   lane_enable,
    input  logic [LANESNUMBER-1:0]   PhyStatus,
    input  logic [3*LANESNUMBER-1:0] RxStatus,
    output logic [4*LANESNUMBER-1:0] PowerDown,
    output logic [LANESNUMBER-1:0]   TxElecIdle,
    output logic [LANESNUMBER-1:0]   TxDetectRx_Loopback,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [LANESNUMBER-1:0]   detected_lanes,
    output logic [2:0]               dbg_state
);
    // Handshake: start is a single-cycle request, accepted only while busy is low;
    // each accepted start ends in exactly one done or one timeout pulse (never both).

    typedef enum logic [2:0] {IDLE, P1_REQ, P1_WAIT, DETECT, DONE} state_t;

    localparam logic [3:0] PD_P1      = 4'b0010;
    localparam logic [2:0] RX_PRESENT = 3'b011;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [LANESNUMBER-1:0]     en_q, en_d;
    logic [LANESNUMBER-1:0]     mask_q, mask_d;
    logic [LANESNUMBER-1:0]     det_q, det_d;
    logic [LANESNUMBER-1:0]     txdet_q, txdet_d;
    logic [LANESNUMBER-1:0]     eidle_q, eidle_d;
    logic [4*LANESNUMBER-1:0]   powerdown_q, powerdown_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;

    logic                       all_p1;
    logic                       cnt_expired;
    logic [LANESNUMBER-1:0]     phy_new;
    logic [LANESNUMBER-1:0]     rx_hit;

    always_comb begin
        all_p1 = 1'b1;
        for (int i = 0; i < LANESNUMBER; i++) begin
            if (lane_enable[i] && (powerdown_q[4*i +: 4] != PD_P1)) all_p1 = 1'b0;
            rx_hit[i] = (RxStatus[3*i +: 3] == RX_PRESENT);
        end
        // Only the first completion of an enabled lane counts; repeats are ignored.
        phy_new     = PhyStatus & en_q & ~mask_q;
        cnt_expired = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        mask_d      = mask_q;
        det_d       = det_q;
        txdet_d     = txdet_q;
        eidle_d     = eidle_q;
        powerdown_d = powerdown_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    en_d   = lane_enable;
                    det_d  = '0;
                    mask_d = '0;
                    cnt_d  = '0;
                    if (all_p1) begin
                        state_d = DETECT;
                        txdet_d = lane_enable;
                    end else begin
                        state_d = P1_REQ;
                    end
                end
            end
            P1_REQ: begin
                for (int i = 0; i < LANESNUMBER; i++) begin
                    if (en_q[i]) begin
                        powerdown_d[4*i +: 4] = PD_P1;
                        eidle_d[i]            = 1'b1;
                    end
                end
                state_d = P1_WAIT;
                cnt_d   = '0;
            end
            P1_WAIT: begin
                mask_d = mask_q | (PhyStatus & en_q);
                if (&(mask_d | ~en_q)) begin
                    mask_d  = '0;
                    state_d = DETECT;
                    txdet_d = en_q;
                    cnt_d   = '0;
                end else if (cnt_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DETECT: begin
                mask_d  = mask_q | phy_new;
                det_d   = det_q | (phy_new & rx_hit);
                txdet_d = txdet_q & ~phy_new;
                // Completion is checked before the timeout so a last-cycle finish still reports done.
                if (&(mask_d | ~en_q)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    txdet_d = '0;
                    cnt_d   = '0;
                end else if (cnt_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    txdet_d   = '0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                txdet_d = '0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q     <= IDLE;
            en_q        <= '0;
            mask_q      <= '0;
            det_q       <= '0;
            txdet_q     <= '0;
            eidle_q     <= '1;
            powerdown_q <= {LANESNUMBER{PD_P1}};
            cnt_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            mask_q      <= mask_d;
            det_q       <= det_d;
            txdet_q     <= txdet_d;
            eidle_q     <= eidle_d;
            powerdown_q <= powerdown_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign PowerDown           = powerdown_q;
    assign TxElecIdle          = eidle_q;
    assign TxDetectRx_Loopback = txdet_q;
    assign busy                = (state_q != IDLE);
    assign done                = done_q;
    assign timeout             = timeout_q;
    assign detected_lanes      = det_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_pipe_rxdetect_ctrl.sv
// Directed bench for pipe_rxdetect_ctrl: drivers push expected {timeout, detected_lanes}
// results; a negedge monitor pops them whenever done or timeout pulses.
module tb_pipe_rxdetect_ctrl;
  localparam int L = 16;
  localparam int W = L + 1;
  localparam logic [3:0] PD_P1 = 4'b0010;
  localparam logic [2:0] S_IDLE = 3'd0, S_P1_REQ = 3'd1, S_P1_WAIT = 3'd2, S_DETECT = 3'd3;

  logic           CLK = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [L-1:0]   lane_enable = '0;
  logic [L-1:0]   PhyStatus = '0;
  logic [3*L-1:0] RxStatus = '0;
  logic [4*L-1:0] PowerDown;
  logic [L-1:0]   TxElecIdle;
  logic [L-1:0]   TxDetectRx_Loopback;
  logic           busy, done, timeout;
  logic [L-1:0]   detected_lanes;
  logic [2:0]     dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pipe_rxdetect_ctrl #(.LANESNUMBER(L), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .CLK(CLK), .reset(reset), .start(start), .lane_enable(lane_enable),
    .PhyStatus(PhyStatus), .RxStatus(RxStatus), .PowerDown(PowerDown),
    .TxElecIdle(TxElecIdle), .TxDetectRx_Loopback(TxDetectRx_Loopback),
    .busy(busy), .done(done), .timeout(timeout),
    .detected_lanes(detected_lanes), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic [3*L-1:0] rx_all(input logic [2:0] code);
    logic [3*L-1:0] v;
    for (int i = 0; i < L; i++) v[3*i +: 3] = code;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
    check({tag, "_pd"}, PowerDown, {L{PD_P1}});
    check({tag, "_eidle"}, 64'(TxElecIdle), 64'({L{1'b1}}));
    check({tag, "_txdet"}, 64'(TxDetectRx_Loopback), 64'd0);
    check({tag, "_busy_done_to"}, 64'({busy, done, timeout}), 64'd0);
    check({tag, "_detected"}, 64'(detected_lanes), 64'd0);
  endtask

  // Drives a one-cycle start at the current negedge; returns at the negedge of cycle N+1.
  task automatic issue_start(input logic [L-1:0] en, input bit push,
                             input logic is_to, input logic [L-1:0] exp_mask);
    if (push) exp_q.push_back({is_to, exp_mask});
    start = 1'b1;
    lane_enable = en;
    tick();
    start = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (reset && (done || timeout)) begin
      logic [W-1:0] exp;
      check("done_and_timeout_exclusive", 64'(done & timeout), 64'd0);
      check("txdet_zero_at_end", 64'(TxDetectRx_Loopback), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_end: got done=%0b timeout=%0b expected none", done, timeout);
      end else begin
        exp = exp_q.pop_front();
        check("end_kind_timeout", 64'(timeout), 64'(exp[W-1]));
        check("end_detected_lanes", 64'(detected_lanes), 64'(exp[L-1:0]));
      end
    end
  end

  initial begin
    logic [3*L-1:0] rx;
    // reset values
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b1;
    tick();

    // 1: all lanes, P1 already set, all present one cycle after detect request
    issue_start('1, 1'b1, 1'b0, 16'hFFFF);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_txdet_rise", 64'(TxDetectRx_Loopback), 64'hFFFF);
    tick();
    PhyStatus = '1;
    RxStatus = rx_all(3'b011);
    tick();
    PhyStatus = '0;
    check("t1_done", 64'(done), 64'd1);
    tick();
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_done_low", 64'(done), 64'd0);

    // 2: lanes 0-3 present at DETECT+2, 4-15 absent at DETECT+5 (0-3 repeat, ignored)
    issue_start('1, 1'b1, 1'b0, 16'h000F);
    tick();
    tick();
    PhyStatus = 16'h000F;
    RxStatus = rx_all(3'b011);
    tick();
    PhyStatus = '0;
    check("t2_txdet_partial", 64'(TxDetectRx_Loopback), 64'hFFF0);
    tick();
    tick();
    PhyStatus = '1;
    RxStatus = rx_all(3'b000);
    tick();
    PhyStatus = '0;
    check("t2_done", 64'(done), 64'd1);
    repeat (3) tick();
    check("t2_detected_held", 64'(detected_lanes), 64'h000F);

    // 3: lanes start in P0; P1 request and P1_WAIT must precede detect
    force dut.powerdown_q = '0;
    issue_start('1, 1'b1, 1'b0, 16'h5555);
    check("t3_state_p1req", 64'(dbg_state), 64'(S_P1_REQ));
    check("t3_no_txdet_p1req", 64'(TxDetectRx_Loopback), 64'd0);
    release dut.powerdown_q;
    tick();
    check("t3_pd_p1", PowerDown, {L{PD_P1}});
    check("t3_state_p1wait", 64'(dbg_state), 64'(S_P1_WAIT));
    PhyStatus = 16'h00FF;
    tick();
    PhyStatus = 16'hFF00;
    check("t3_still_waiting", 64'(dbg_state), 64'(S_P1_WAIT));
    check("t3_no_txdet_wait", 64'(TxDetectRx_Loopback), 64'd0);
    tick();
    PhyStatus = '0;
    check("t3_state_detect", 64'(dbg_state), 64'(S_DETECT));
    check("t3_txdet_rise", 64'(TxDetectRx_Loopback), 64'hFFFF);
    for (int i = 0; i < L; i++) rx[3*i +: 3] = (i % 2 == 0) ? 3'b011 : 3'b010;
    RxStatus = rx;
    PhyStatus = '1;
    tick();
    PhyStatus = '0;
    tick();

    // 4: lane 7 silent -> timeout 16 cycles into DETECT
    issue_start('1, 1'b1, 1'b1, 16'hFF7F);
    tick();
    PhyStatus = 16'hFF7F;
    RxStatus = rx_all(3'b011);
    tick();
    PhyStatus = '0;
    check("t4_txdet_lane7", 64'(TxDetectRx_Loopback), 64'h0080);
    repeat (13) tick();
    check("t4_no_timeout_early", 64'(timeout), 64'd0);
    check("t4_busy_before_to", 64'(busy), 64'd1);
    tick();
    check("t4_timeout", 64'(timeout), 64'd1);
    check("t4_busy_after_to", 64'(busy), 64'd0);
    tick();
    check("t4_timeout_pulse", 64'(timeout), 64'd0);

    // 5: lanes 0-7 only; upper PhyStatus must be ignored, upper requests stay low
    issue_start(16'h00FF, 1'b1, 1'b0, 16'h00FF);
    check("t5_txdet", 64'(TxDetectRx_Loopback), 64'h00FF);
    PhyStatus = 16'hFF00;
    tick();
    check("t5_upper_ignored", 64'(TxDetectRx_Loopback), 64'h00FF);
    PhyStatus = 16'hFFFF;
    tick();
    PhyStatus = '0;
    check("t5_done", 64'(done), 64'd1);
    tick();

    // 7: no lanes enabled -> straight to DONE with empty result
    issue_start('0, 1'b1, 1'b0, 16'h0000);
    check("t7_state_detect", 64'(dbg_state), 64'(S_DETECT));
    check("t7_txdet", 64'(TxDetectRx_Loopback), 64'd0);
    tick();
    check("t7_done", 64'(done), 64'd1);
    tick();

    // 6: second start while busy ignored; reset in DETECT aborts silently
    issue_start('1, 1'b0, 1'b0, 16'h0000);
    PhyStatus = 16'h0001;
    RxStatus = rx_all(3'b011);
    start = 1'b1;
    lane_enable = '0;
    tick();
    start = 1'b0;
    PhyStatus = '0;
    check("t6_restart_ignored", 64'(TxDetectRx_Loopback), 64'hFFFE);
    check("t6_state_detect", 64'(dbg_state), 64'(S_DETECT));
    check("t6_partial_detect", 64'(detected_lanes), 64'h0001);
    reset = 1'b0;
    tick();
    check_reset_vals("t6_midreset");
    reset = 1'b1;
    repeat (4) tick();
    check("t6_idle_after", 64'(busy), 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
